// File: rtl/mmcm_range_pkg.sv
// rtl/mmcm_range_pkg.sv - shared types and helpers for the MMCM range tracker
package mmcm_range_pkg;

  typedef enum logic [2:0] {
    S_ACQUIRE,
    S_SET,
    S_STEP,
    S_WAIT_RDY,
    S_LOCKED,
    S_FAIL
  } state_t;

  localparam int MAX_W      = 32;
  localparam int MAX_RANGES = 8;

  // Gray to binary over a fixed 32-bit container; callers zero-extend and truncate.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Extract threshold slice idx of width cnt_w from a zero-extended packed vector.
  function automatic logic [MAX_W-1:0] thresh_at(input logic [MAX_RANGES*MAX_W-1:0] vec,
                                                 input int cnt_w, input int idx);
    logic [MAX_RANGES*MAX_W-1:0] sh;
    logic [MAX_W-1:0]            mask;
    sh   = vec >> (idx * cnt_w);
    mask = (cnt_w >= MAX_W) ? '1 : ((32'd1 << cnt_w) - 32'd1);
    return sh[MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/range_classifier.sv
// rtl/range_classifier.sv - band compare of window delta plus stability filter
module range_classifier
  import mmcm_range_pkg::*;
#(
  parameter int NUM_RANGES     = 5,
  parameter int CNT_W          = 12,
  parameter logic [(NUM_RANGES-1)*CNT_W-1:0] THRESH = {12'd330, 12'd155, 12'd70, 12'd35},
  parameter int STABLE_WINDOWS = 3,
  localparam int BAND_W        = $clog2(NUM_RANGES)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              eval,
  input  logic [CNT_W-1:0]  delta,
  output logic [BAND_W-1:0] band,
  output logic              qualified,
  output logic              done
);

  localparam int SW = $clog2(STABLE_WINDOWS + 1);
  localparam logic [MAX_RANGES*MAX_W-1:0] THR_EXT =
    {{(MAX_RANGES*MAX_W - (NUM_RANGES-1)*CNT_W){1'b0}}, THRESH};

  logic [BAND_W-1:0] band_c;
  logic [SW-1:0]     stable_cnt;

  // Band is the number of thresholds strictly exceeded; equality stays in the lower band.
  always_comb begin
    band_c = '0;
    for (int i = 0; i < NUM_RANGES - 1; i++) begin
      if (32'(delta) > thresh_at(THR_EXT, CNT_W, i)) begin
        band_c = band_c + BAND_W'(1);
      end
    end
  end

  // Register the band one cycle after the snapshot and track how long it has held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      band       <= '0;
      stable_cnt <= '0;
      done       <= 1'b0;
    end else begin
      done <= eval;
      if (eval) begin
        band <= band_c;
        if (band_c == band) begin
          if (stable_cnt != SW'(STABLE_WINDOWS)) begin
            stable_cnt <= stable_cnt + SW'(1);
          end
        end else begin
          stable_cnt <= SW'(1);
        end
      end
    end
  end

  assign qualified = (stable_cnt == SW'(STABLE_WINDOWS));

endmodule

// File: rtl/mmcm_range_tracker.sv
// rtl/mmcm_range_tracker.sv - DCO rate band tracker driving the MMCM DRP step handshake
module mmcm_range_tracker
  import mmcm_range_pkg::*;
#(
  parameter int NUM_RANGES     = 5,
  parameter int MODE_W         = 3,
  parameter int MODE_BASE      = 1,
  parameter int CNT_W          = 12,
  parameter int GATE_CYCLES    = 1024,
  parameter logic [(NUM_RANGES-1)*CNT_W-1:0] THRESH = {12'd330, 12'd155, 12'd70, 12'd35},
  parameter int STABLE_WINDOWS = 3,
  parameter int RDY_TIMEOUT    = 65535,
  parameter int MAX_RETRY      = 3,
  parameter bit CONTINUOUS     = 1'b1
) (
  input  logic              clkin,
  input  logic              reset_n,
  input  logic              dut_sync_rdy,
  input  logic [CNT_W-1:0]  dco_cnt_gray,
  input  logic              srdy,
  output logic [MODE_W-1:0] freq_mode,
  output logic              drp_start,
  output logic              count_done,
  output logic              locked,
  output logic              band_chg,
  output logic              err
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int TO_W   = $clog2(RDY_TIMEOUT + 1);
  localparam int RTY_W  = $clog2(MAX_RETRY + 1);
  localparam int BAND_W = $clog2(NUM_RANGES);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    dco_bin, snap_cur, snap_last, delta;
  logic [GATE_W-1:0]   gate_cnt;
  logic                prev_vld, snap_vld, meas_run, gate_tc;
  logic [BAND_W-1:0]   band;
  logic                qualified, qual_evt, set_mode, to_hit;
  logic [MODE_W-1:0]   cand;
  logic [TO_W-1:0]     to_cnt;
  logic [RTY_W-1:0]    retry;

  assign dco_bin  = CNT_W'(gray2bin(32'(dco_cnt_gray)));
  assign meas_run = dut_sync_rdy && !(!CONTINUOUS && state == S_LOCKED);
  assign gate_tc  = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
  assign delta    = snap_cur - snap_last;

  // Gate counter and snapshot pair; the first snapshot after enabling only primes.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      gate_cnt  <= '0;
      snap_cur  <= '0;
      snap_last <= '0;
      prev_vld  <= 1'b0;
      snap_vld  <= 1'b0;
    end else begin
      snap_vld <= 1'b0;
      if (!meas_run) begin
        gate_cnt <= '0;
        prev_vld <= 1'b0;
      end else if (gate_tc) begin
        gate_cnt  <= '0;
        snap_cur  <= dco_bin;
        snap_last <= snap_cur;
        snap_vld  <= prev_vld;
        prev_vld  <= 1'b1;
      end else begin
        gate_cnt <= gate_cnt + GATE_W'(1);
      end
    end
  end

  range_classifier #(
    .NUM_RANGES     (NUM_RANGES),
    .CNT_W          (CNT_W),
    .THRESH         (THRESH),
    .STABLE_WINDOWS (STABLE_WINDOWS)
  ) u_classifier (
    .clk       (clkin),
    .reset_n   (reset_n),
    .eval      (snap_vld),
    .delta     (delta),
    .band      (band),
    .qualified (qualified),
    .done      (count_done)
  );

  assign qual_evt = count_done && qualified;
  assign cand     = MODE_W'(MODE_BASE) + MODE_W'(band);
  assign to_hit   = (to_cnt == TO_W'(RDY_TIMEOUT - 1));

  // Next-state and Moore/Mealy outputs of the step/lock handshake.
  always_comb begin
    state_nx  = state;
    drp_start = 1'b0;
    band_chg  = 1'b0;
    locked    = 1'b0;
    err       = 1'b0;
    set_mode  = 1'b0;
    case (state)
      S_ACQUIRE: begin
        if (qual_evt) begin
          set_mode = 1'b1;
          state_nx = S_SET;
        end
      end
      S_SET:  state_nx = S_STEP;
      S_STEP: begin
        drp_start = 1'b1;
        state_nx  = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (srdy) begin
          state_nx = S_LOCKED;
        end else if (to_hit) begin
          state_nx = (retry < RTY_W'(MAX_RETRY)) ? S_STEP : S_FAIL;
        end
      end
      S_LOCKED: begin
        locked = 1'b1;
        if (CONTINUOUS && qual_evt && cand != freq_mode) begin
          band_chg = 1'b1;
          locked   = 1'b0;
          set_mode = 1'b1;
          state_nx = S_SET;
        end
      end
      S_FAIL:  err = 1'b1;
      default: state_nx = S_ACQUIRE;
    endcase
  end

  // State, mode register, srdy timeout and retry bookkeeping.
  always_ff @(posedge clkin) begin
    if (!reset_n) begin
      state     <= S_ACQUIRE;
      freq_mode <= MODE_W'(MODE_BASE);
      to_cnt    <= '0;
      retry     <= '0;
    end else begin
      state <= state_nx;
      if (set_mode) begin
        freq_mode <= cand;
      end
      case (state)
        S_STEP: to_cnt <= '0;
        S_WAIT_RDY: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (srdy) begin
            retry <= '0;
          end else if (to_hit && retry < RTY_W'(MAX_RETRY)) begin
            retry <= retry + RTY_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmcm_range_tracker.sv
// tb/tb_mmcm_range_tracker.sv - directed self-checking bench for mmcm_range_tracker
module tb_mmcm_range_tracker;

  logic        clkin = 1'b0;
  logic        reset_n = 1'b0;
  logic        dut_sync_rdy = 1'b0;
  logic        srdy = 1'b0;
  logic [11:0] dco_cnt_gray = '0;
  logic [2:0]  freq_mode;
  logic        drp_start, count_done, locked, band_chg, err;

  mmcm_range_tracker #(
    .GATE_CYCLES (100),
    .RDY_TIMEOUT (50),
    .MAX_RETRY   (2)
  ) dut (
    .clkin        (clkin),
    .reset_n      (reset_n),
    .dut_sync_rdy (dut_sync_rdy),
    .dco_cnt_gray (dco_cnt_gray),
    .srdy         (srdy),
    .freq_mode    (freq_mode),
    .drp_start    (drp_start),
    .count_done   (count_done),
    .locked       (locked),
    .band_chg     (band_chg),
    .err          (err)
  );

  always #5 clkin = ~clkin;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int unsigned acc = 0;
  int unsigned rate = 0;
  int          n_drp = 0;
  int          n_done = 0;
  int          drp_cyc[$];

  task automatic step();
    logic [11:0] b;
    @(posedge clkin);
    #1;
    cyc++;
    acc += rate;
    b = 12'((acc / 100) % 4096);
    dco_cnt_gray = b ^ (b >> 1);
    if (drp_start === 1'b1) begin
      n_drp++;
      drp_cyc.push_back(cyc);
    end
    if (count_done === 1'b1) n_done++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_mode(input logic [2:0] from, input int lim, output int n);
    n = 0;
    while (freq_mode === from && n < lim) begin step(); n++; end
  endtask

  task automatic wait_bchg(input int lim, output int n);
    n = 0;
    while (band_chg !== 1'b1 && n < lim) begin step(); n++; end
  endtask

  task automatic wait_drp(input int lim, output int n);
    n = 0;
    while (drp_start !== 1'b1 && n < lim) begin step(); n++; end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dut_sync_rdy = 1'b0;
    srdy = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Relock to a new rate from LOCKED, expecting a band_chg and a single re-step.
  task automatic relock(input string tag, input int unsigned new_rate,
                        input logic [2:0] old_mode, input logic [2:0] new_mode);
    int n;
    int d0;
    d0 = n_drp;
    rate = new_rate;
    wait_bchg(1000, n);
    chk({tag, "_bchg_seen"}, 32'(n < 1000), 1);
    chk({tag, "_locked_drop"}, 32'(locked), 0);
    chk({tag, "_mode_hold"}, 32'(freq_mode), 32'(old_mode));
    step();
    chk({tag, "_bchg_pulse"}, 32'(band_chg), 0);
    chk({tag, "_mode_new"}, 32'(freq_mode), 32'(new_mode));
    wait_drp(10, n);
    chk({tag, "_drp_seen"}, 32'(n < 10), 1);
    srdy = 1'b1;
    step();
    chk({tag, "_srdy_in_step_ignored"}, 32'(locked), 0);
    step();
    srdy = 1'b0;
    chk({tag, "_locked"}, 32'(locked), 1);
    chk({tag, "_one_drp"}, 32'(n_drp - d0), 1);
  endtask

  initial begin
    int n;
    int ecyc;
    int d0;

    // Reset state
    repeat (3) step();
    chk("rst_mode", 32'(freq_mode), 1);
    chk("rst_drp", 32'(drp_start), 0);
    chk("rst_done", 32'(count_done), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_bchg", 32'(band_chg), 0);
    chk("rst_err", 32'(err), 0);

    // 250/window -> band 3: priming + 3 evaluated windows, mode change at enable+402
    reset_n = 1'b1;
    rate = 250;
    step();
    dut_sync_rdy = 1'b1;
    n_done = 0;
    wait_mode(3'd1, 1000, n);
    chk("b3_latency", 32'(n), 402);
    chk("b3_mode", 32'(freq_mode), 4);
    chk("b3_done_cnt", 32'(n_done), 3);
    chk("b3_drp_before", 32'(drp_start), 0);
    step();
    chk("b3_drp_pulse", 32'(drp_start), 1);
    step();
    chk("b3_drp_width", 32'(drp_start), 0);
    repeat (8) step();
    chk("b3_not_locked_yet", 32'(locked), 0);
    srdy = 1'b1;
    step();
    srdy = 1'b0;
    chk("b3_locked", 32'(locked), 1);
    chk("b3_err", 32'(err), 0);

    // Threshold equality stays low, one above moves up, then a big downward move
    relock("d155", 155, 3'd4, 3'd3);
    relock("d156", 156, 3'd3, 3'd4);
    relock("d50", 50, 3'd4, 3'd2);

    // Counter wraps 0xFFF->0x000 inside an evaluated window; reset during WAIT_RDY
    do_reset();
    acc = (4096 - 300) * 100;
    rate = 250;
    step();
    dut_sync_rdy = 1'b1;
    wait_mode(3'd1, 1000, n);
    chk("wrap_latency", 32'(n), 402);
    chk("wrap_mode", 32'(freq_mode), 4);
    step();
    chk("wrap_drp", 32'(drp_start), 1);
    step();
    reset_n = 1'b0;
    step();
    chk("midrst_mode", 32'(freq_mode), 1);
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_drp", 32'(drp_start), 0);
    chk("midrst_done", 32'(count_done), 0);
    reset_n = 1'b1;
    d0 = n_drp;
    repeat (20) step();
    chk("midrst_no_drp", 32'(n_drp - d0), 0);

    // srdy never arrives: steps at +0, +51, +102, then sticky err at +153
    do_reset();
    rate = 250;
    step();
    dut_sync_rdy = 1'b1;
    wait_mode(3'd1, 1000, n);
    chk("to_mode", 32'(freq_mode), 4);
    drp_cyc.delete();
    n = 0;
    while (err !== 1'b1 && n < 400) begin step(); n++; end
    ecyc = cyc;
    chk("to_err_seen", 32'(n < 400), 1);
    chk("to_drp_count", 32'(drp_cyc.size()), 3);
    chk("to_retry1_gap", 32'((drp_cyc.size() >= 2) ? drp_cyc[1] - drp_cyc[0] : -1), 51);
    chk("to_retry2_gap", 32'((drp_cyc.size() >= 3) ? drp_cyc[2] - drp_cyc[0] : -1), 102);
    chk("to_err_gap", 32'((drp_cyc.size() >= 1) ? ecyc - drp_cyc[0] : -1), 153);
    chk("to_locked", 32'(locked), 0);
    repeat (200) step();
    chk("to_no_more_drp", 32'(drp_cyc.size()), 3);
    chk("to_err_sticky", 32'(err), 1);
    reset_n = 1'b0;
    step();
    chk("to_err_cleared", 32'(err), 0);

    // Alternating 250/60 per window never qualifies
    do_reset();
    rate = 250;
    step();
    dut_sync_rdy = 1'b1;
    n_done = 0;
    d0 = n_drp;
    for (int i = 1; i <= 805; i++) begin
      rate = (((i - 1) / 100) % 2 == 1) ? 60 : 250;
      step();
    end
    chk("alt_done_cnt", 32'(n_done), 7);
    chk("alt_no_drp", 32'(n_drp - d0), 0);
    chk("alt_mode", 32'(freq_mode), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
